fix_serializer: RTL and testbench
=================================

Name: fix_serializer

Overview:
Transmit-side counterpart of the FIX parser. It takes tag/value pairs, one pair per handshake, and serializes each as ASCII "tag=value<SOH>" onto a byte stream with valid/ready backpressure. A running sum-mod-256 of every emitted byte is kept per message. When a pair is flagged last, the block appends the FIX trailer "10=ddd<SOH>" and then starts a new message. Upstream is a tag/value FIFO pair; downstream is a byte link or buffer.

Parameters:
TAG_BYTES, 4, maximum tag length in ASCII chars; tag_i width is 8*TAG_BYTES.
VAL_BYTES, 32, maximum value length in ASCII chars; value_i width is 8*VAL_BYTES.
SOH_CHAR, 8'h01, field delimiter byte.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
in_valid_i  in  1  tag/value pair present
in_ready_o  out  1  block accepts the pair this cycle
tag_i  in  32  tag ASCII, first char in bits [31:24], left-justified
tag_len_i  in  3  tag char count, 1..4
value_i  in  256  value ASCII, first char in bits [255:248], left-justified
value_len_i  in  6  value char count, 0..32
last_i  in  1  pair is the final body field; trailer follows
data_o  out  8  serialized byte
valid_o  out  1  data_o valid
ready_i  in  1  downstream takes the byte
msg_done_o  out  1  one-cycle pulse when the trailer SOH is transferred
checksum_o  out  8  running checksum of the current message

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, in_ready_o=0, valid_o=0, data_o=0, msg_done_o=0, checksum_o=0, all counters and registers 0. in_ready_o rises in the first IDLE cycle after reset release.
- Accept:
  - in_ready_o=1 only in IDLE.
  - On in_valid_i&in_ready_o, register tag, value, lengths and last, then go to TAG.
  - The first byte appears on valid_o the next cycle (latency 1).
- Output handshake:
  - A byte transfers on valid_o&ready_i.
  - While ready_i=0, data_o and valid_o hold stable.
  - valid_o is never withdrawn without a transfer.
- FSM (each state advances only on a transfer):
  - IDLE.
  - TAG: emit tag chars MSB-first; index counts 0..len-1.
  - EQ: emit 8'h3D.
  - VAL: emit value chars; skipped entirely when the latched value_len is 0.
  - SOH: emit SOH_CHAR. Next state is CK_TAG if last, else IDLE.
  - CK_TAG: emit '1','0','=' (3 bytes).
  - CK_D2, CK_D1, CK_D0: emit the hundreds, tens and units decimal ASCII digits of the frozen checksum (8'h30+digit), always 3 digits with leading zeros.
  - CK_SOH: emit SOH, pulse msg_done_o in the transfer cycle, clear the checksum, return to IDLE.
- Length rules: tag_len 0 is treated as 1; tag_len >4 saturates to 4; value_len >32 saturates to 32.
- Checksum:
  - checksum += data_o (mod 256, 8-bit wrap) on each transfer in TAG, EQ, VAL and SOH.
  - It is frozen from CK_TAG entry and not updated by trailer bytes.
  - Digit conversion uses the frozen value: 0..255 split into hundreds, tens and units.
- Each pair costs len_tag+1+len_val+1 transfers plus 1 IDLE cycle. No pipelining across pairs.
- A reset mid-message aborts immediately. No partial trailer is emitted and the checksum clears.
- ready_i held low indefinitely produces a stall only: no state change, no checksum change.

Test Plan:
1. tag "35" (tag_i=32'h33350000, len 2), value "A" (len 1), last=1, ready_i=1 -> bytes 33 35 3D 41 01 31 30 3D 32 33 31 01 ("35=A|10=231|"), msg_done_o pulses on the final 01, checksum_o returns to 0.
2. Same pair with ready_i toggled 1/0 every cycle -> identical byte sequence, data_o stable during every ready_i=0 cycle, no duplicated or dropped bytes.
3. Two pairs, tag "8" value "FIX.4.2" (last=0) then tag "35" value "0" (last=1) -> "8=FIX.4.2|35=0|10=ddd|", where ddd is the 3-digit decimal of the byte sum mod 256; the sum exceeds 255 and wraps. in_ready_o is low from acceptance until the SOH of pair 1.
4. value_len_i=0 with tag "58" -> "58=" then SOH; tag_len_i=0 with tag_i=32'h39000000 -> single-char tag "9".
5. Checksum whose result is <10 (e.g. a message summing to 0x105) -> trailer digits "005" with leading zeros.
6. Assert rst low during VAL of a 32-char value -> valid_o=0 asynchronously. After release, a new pair "35=A" last yields trailer "10=231", proving the checksum cleared.

Source files
------------

// File: rtl/fix_serializer.sv
// FIX tag=value serializer: one pair per handshake out as ASCII "tag=value<SOH>",
// with a "10=ddd<SOH>" sum-mod-256 trailer appended after the last pair of a message.
module fix_serializer #(
  parameter int          TAG_BYTES = 4,
  parameter int          VAL_BYTES = 32,
  parameter logic [7:0]  SOH_CHAR  = 8'h01,
  localparam int         TW        = 8*TAG_BYTES,
  localparam int         VW        = 8*VAL_BYTES,
  localparam int         TLW       = $clog2(TAG_BYTES+1),
  localparam int         VLW       = $clog2(VAL_BYTES+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [TW-1:0]  tag_i,
  input  logic [TLW-1:0] tag_len_i,
  input  logic [VW-1:0]  value_i,
  input  logic [VLW-1:0] value_len_i,
  input  logic           last_i,
  output logic [7:0]     data_o,
  output logic           valid_o,
  input  logic           ready_i,
  output logic           msg_done_o,
  output logic [7:0]     checksum_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_TAG, S_EQ, S_VAL, S_SOH, S_CK_TAG, S_CK_D2, S_CK_D1, S_CK_D0, S_CK_SOH
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [TW-1:0]  r_tag;
  logic [VW-1:0]  r_val;
  logic [TLW-1:0] r_tlen, w_tlen_sat;
  logic [VLW-1:0] r_vlen, w_vlen_sat;
  logic           r_last;
  logic [VLW-1:0] r_idx;
  logic [7:0]     r_cksum;
  logic           r_alive;
  logic           w_xfer, w_accept;
  logic           w_tag_end, w_val_end, w_ck_end;
  logic [7:0]     w_d2, w_d1, w_d0;

  assign w_xfer   = valid_o & ready_i;
  assign w_accept = in_valid_i & in_ready_o;

  // Out-of-range lengths are clamped so a bad upstream length can never hang the FSM.
  always_comb begin
    w_tlen_sat = tag_len_i;
    if (tag_len_i == '0)                    w_tlen_sat = TLW'(1);
    else if (tag_len_i > TLW'(TAG_BYTES))   w_tlen_sat = TLW'(TAG_BYTES);
    w_vlen_sat = value_len_i;
    if (value_len_i > VLW'(VAL_BYTES))      w_vlen_sat = VLW'(VAL_BYTES);
  end

  assign w_tag_end = (r_idx == VLW'(r_tlen) - VLW'(1));
  assign w_val_end = (r_idx == r_vlen - VLW'(1));
  assign w_ck_end  = (r_idx == VLW'(2));

  // r_cksum does not move during the trailer, so the digits come straight from it.
  assign w_d2 = r_cksum / 8'd100;
  assign w_d1 = (r_cksum / 8'd10) % 8'd10;
  assign w_d0 = r_cksum % 8'd10;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept)             w_state_nxt = S_TAG;
      S_TAG:    if (w_xfer && w_tag_end)  w_state_nxt = S_EQ;
      S_EQ:     if (w_xfer)               w_state_nxt = (r_vlen == '0) ? S_SOH : S_VAL;
      S_VAL:    if (w_xfer && w_val_end)  w_state_nxt = S_SOH;
      S_SOH:    if (w_xfer)               w_state_nxt = r_last ? S_CK_TAG : S_IDLE;
      S_CK_TAG: if (w_xfer && w_ck_end)   w_state_nxt = S_CK_D2;
      S_CK_D2:  if (w_xfer)               w_state_nxt = S_CK_D1;
      S_CK_D1:  if (w_xfer)               w_state_nxt = S_CK_D0;
      S_CK_D0:  if (w_xfer)               w_state_nxt = S_CK_SOH;
      S_CK_SOH: if (w_xfer)               w_state_nxt = S_IDLE;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    data_o     = 8'h00;
    valid_o    = (r_state != S_IDLE);
    in_ready_o = (r_state == S_IDLE) & r_alive;
    msg_done_o = (r_state == S_CK_SOH) & ready_i;
    checksum_o = r_cksum;
    case (r_state)
      S_TAG:    data_o = r_tag[TW-1 -: 8];
      S_EQ:     data_o = 8'h3D;
      S_VAL:    data_o = r_val[VW-1 -: 8];
      S_SOH:    data_o = SOH_CHAR;
      S_CK_TAG: data_o = (r_idx == '0) ? 8'h31 : (r_idx == VLW'(1)) ? 8'h30 : 8'h3D;
      S_CK_D2:  data_o = 8'h30 + w_d2;
      S_CK_D1:  data_o = 8'h30 + w_d1;
      S_CK_D0:  data_o = 8'h30 + w_d0;
      S_CK_SOH: data_o = SOH_CHAR;
      default:  data_o = 8'h00;
    endcase
  end

  // Tag/value are shifted left per transfer so the next char always sits in the top byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag   <= '0;
      r_val   <= '0;
      r_tlen  <= '0;
      r_vlen  <= '0;
      r_last  <= 1'b0;
      r_idx   <= '0;
      r_cksum <= '0;
      r_alive <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      if (w_accept) begin
        r_tag  <= tag_i;
        r_val  <= value_i;
        r_tlen <= w_tlen_sat;
        r_vlen <= w_vlen_sat;
        r_last <= last_i;
        r_idx  <= '0;
      end else if (w_xfer) begin
        if (r_state == S_TAG) r_tag <= r_tag << 8;
        if (r_state == S_VAL) r_val <= r_val << 8;
        r_idx <= (w_state_nxt != r_state) ? '0 : r_idx + VLW'(1);
        case (r_state)
          S_TAG, S_EQ, S_VAL, S_SOH: r_cksum <= r_cksum + data_o;
          S_CK_SOH:                  r_cksum <= '0;
          default:                   r_cksum <= r_cksum;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fix_serializer.sv
// Directed bench for fix_serializer: a byte-queue model built from the pair rules is
// checked every cycle, plus literal expected byte strings for the directed cases.
module tb_fix_serializer;
  logic         clk = 1'b0, rst = 1'b0;
  logic         in_valid_i = 1'b0, in_ready_o;
  logic [31:0]  tag_i = '0;
  logic [2:0]   tag_len_i = '0;
  logic [255:0] value_i = '0;
  logic [5:0]   value_len_i = '0;
  logic         last_i = 1'b0;
  logic [7:0]   data_o, checksum_o;
  logic         valid_o, msg_done_o;
  logic         ready_i = 1'b1;

  fix_serializer dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .tag_i(tag_i), .tag_len_i(tag_len_i), .value_i(value_i), .value_len_i(value_len_i),
    .last_i(last_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .msg_done_o(msg_done_o), .checksum_o(checksum_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] b; bit body; bit eom; } exp_t;
  exp_t       q[$];
  logic [7:0] cap[$];
  int         b_sum = 0;
  logic [7:0] m_sum = '0;
  int         post_rst = 0;
  bit         rdy_mode = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_d = '0;
  int         checks = 0, passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [255:0] vstr(input logic [255:0] s, input int n);
    return (n == 0) ? '0 : s << (8*(32-n));
  endfunction

  function automatic logic [31:0] tstr(input logic [31:0] s, input int n);
    return s << (8*(4-n));
  endfunction

  function automatic void push_b(input logic [7:0] b, input bit body, input bit eom);
    exp_t e;
    e.b = b; e.body = body; e.eom = eom;
    q.push_back(e);
    if (body) b_sum = (b_sum + b) % 256;
  endfunction

  // Model: expand one accepted pair into its byte stream.
  function automatic void model_push(input logic [31:0] t, input int tl, input logic [255:0] v,
                                     input int vl, input bit l);
    int te, ve;
    te = (tl == 0) ? 1 : (tl > 4 ? 4 : tl);
    ve = (vl > 32) ? 32 : vl;
    for (int i = 0; i < te; i++) push_b(t[31-8*i -: 8], 1, 0);
    push_b(8'h3D, 1, 0);
    for (int i = 0; i < ve; i++) push_b(v[255-8*i -: 8], 1, 0);
    push_b(8'h01, 1, 0);
    if (l) begin
      int s;
      s = b_sum;
      push_b(8'h31, 0, 0); push_b(8'h30, 0, 0); push_b(8'h3D, 0, 0);
      push_b(8'(8'h30 + s/100), 0, 0);
      push_b(8'(8'h30 + (s/10)%10), 0, 0);
      push_b(8'(8'h30 + s%10), 0, 0);
      push_b(8'h01, 0, 1);
      b_sum = 0;
    end
  endfunction

  task automatic send(input logic [31:0] t, input int tl, input logic [255:0] v,
                      input int vl, input bit l);
    int n;
    n = 0;
    @(posedge clk); #1;
    tag_i = t; tag_len_i = 3'(tl); value_i = v; value_len_i = 6'(vl); last_i = l;
    in_valid_i = 1'b1;
    @(negedge clk);
    while (!in_ready_o && n < 500) begin @(negedge clk); n++; end
    if (!in_ready_o) begin
      chk("accept_timeout", 32'(in_ready_o), 32'd1);
      in_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    model_push(t, tl, v, vl, l);
    #1 in_valid_i = 1'b0;
    @(negedge clk);
    chk("latency1_valid", 32'(valid_o), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    chk("drain", q.size(), 0);
    @(negedge clk);
  endtask

  task automatic chk_digits(input string name, input int base, input logic [23:0] lit);
    chk(name, cap.size() > base+2 ? {8'h0, cap[base], cap[base+1], cap[base+2]} : 32'hFFFFFFFF,
        {8'h0, lit});
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) post_rst++; else post_rst = 0;
  end

  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode) ready_i = ~ready_i; else ready_i = 1'b1;
  end

  // Per-cycle compare against the model queue.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_in_ready", 32'(in_ready_o), 0);
      chk("rst_data", 32'(data_o), 0);
      chk("rst_cksum", 32'(checksum_o), 0);
      chk("rst_done", 32'(msg_done_o), 0);
      prev_stall = 0;
    end else begin
      bit has, dn;
      has = (q.size() != 0);
      dn  = has && ready_i && q[0].eom;
      chk("valid", 32'(valid_o), 32'(has));
      if (has) chk("data", 32'(data_o), 32'(q[0].b));
      if (prev_stall) chk("hold_data", 32'(data_o), 32'(prev_d));
      chk("checksum", 32'(checksum_o), 32'(m_sum));
      chk("msg_done", 32'(msg_done_o), 32'(dn));
      if (has) chk("in_ready_busy", 32'(in_ready_o), 0);
      else if (post_rst >= 1) chk("in_ready_idle", 32'(in_ready_o), 1);
      prev_stall = valid_o && !ready_i;
      prev_d = data_o;
      if (has && ready_i) begin
        exp_t e;
        e = q.pop_front();
        cap.push_back(data_o);
        if (e.body) m_sum = m_sum + e.b;
        if (e.eom) m_sum = '0;
      end
    end
  end

  logic [95:0] t1_lit;

  initial begin
    t1_lit = 96'h33_35_3D_41_01_31_30_3D_32_33_31_01;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: "35=A" last, full-rate sink
    cap.delete();
    send(tstr("35", 2), 2, vstr("A", 1), 1, 1);
    drain();
    chk("t1_len", cap.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < cap.size()) chk("t1_byte", 32'(cap[i]), 32'(t1_lit[95-8*i -: 8]));

    // 2: same pair with ready toggling
    cap.delete(); rdy_mode = 1;
    send(tstr("35", 2), 2, vstr("A", 1), 1, 1);
    drain();
    rdy_mode = 0;
    chk("t2_len", cap.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < cap.size()) chk("t2_byte", 32'(cap[i]), 32'(t1_lit[95-8*i -: 8]));

    // 3: two-pair message, sum wraps past 255 -> 245
    cap.delete();
    send(tstr("8", 1), 1, vstr("FIX.4.2", 7), 7, 0);
    send(tstr("35", 2), 2, vstr("0", 1), 1, 1);
    drain();
    chk("t3_len", cap.size(), 22);
    chk_digits("t3_digits", 18, "245");

    // 4: empty value, then tag_len 0 treated as one char
    cap.delete();
    send(tstr("58", 2), 2, '0, 0, 0);
    send(32'h39000000, 0, vstr("1", 1), 1, 1);
    drain();
    chk("t4_len", cap.size(), 15);
    if (cap.size() >= 8) begin
      chk("t4_pair1", {cap[0], cap[1], cap[2], cap[3]}, 32'h35383D01);
      chk("t4_pair2", {cap[4], cap[5], cap[6], cap[7]}, 32'h393D3101);
    end
    chk_digits("t4_digits", 11, "083");

    // 5: body sums to 0x105 -> "005"
    cap.delete();
    send(tstr("9", 1), 1, vstr("FH", 2), 2, 1);
    drain();
    chk_digits("t5_digits", 8, "005");

    // 7: tag_len 7 -> 4 chars, value_len 45 -> 32 chars
    cap.delete();
    send(32'h35353535, 7, {32{8'h61}}, 45, 1);
    drain();
    chk("t7_len", cap.size(), 45);

    // 6: reset during a 32-char value, then a fresh "35=A" message
    cap.delete();
    begin
      int n;
      n = 0;
      send(tstr("58", 2), 2, {32{8'h62}}, 32, 1);
      while (cap.size() < 10 && n < 200) begin @(negedge clk); n++; end
      chk("t6_reach_val", 32'(cap.size() >= 10), 1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete(); cap.delete(); b_sum = 0; m_sum = '0;
    #1;
    chk("t6_async_valid", 32'(valid_o), 0);
    chk("t6_async_cksum", 32'(checksum_o), 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    send(tstr("35", 2), 2, vstr("A", 1), 1, 1);
    drain();
    chk("t6_len", cap.size(), 12);
    chk_digits("t6_digits", 8, "231");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
